// File: rtl/ext_bus_arbiter.sv
// Two-master round-robin arbiter and strobe/ready sequencer for the external memory bus.
// Master 0 is the CPU load/store path, master 1 the DMA/loader; one transfer in flight at a time.
module ext_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready,
    output logic              o_grant,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STROBE  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pref_q, pref_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              bus_clk_q, bus_clk_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m0_err_q, m0_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic              m1_ack_q, m1_ack_d;
    logic              m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              any_req;
    logic              win;
    logic              timed_out;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_data;

    // On a tie the master that was not granted last wins; a lone requester always wins.
    always_comb begin
        any_req   = i_m0_req | i_m1_req;
        win       = (i_m0_req && i_m1_req) ? pref_q : i_m1_req;
        timed_out = (cnt_q == TIMEOUT_CNT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_req) state_d = S_STROBE;
            S_STROBE:  if (i_bus_data_ready || timed_out) state_d = S_RELEASE;
            S_RELEASE: if (!i_bus_data_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        pref_d     = pref_q;
        grant_d    = grant_q;
        bus_clk_d  = bus_clk_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        m0_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_ack_d   = 1'b0;
        m1_err_d   = 1'b0;
        m1_rdata_d = m1_rdata_q;
        done       = 1'b0;
        done_err   = 1'b0;
        done_data  = '0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    bus_we_d   = win ? i_m1_we    : i_m0_we;
                    bus_addr_d = win ? i_m1_addr  : i_m0_addr;
                    bus_data_d = win ? i_m1_wdata : i_m0_wdata;
                    bus_clk_d  = 1'b1;
                    grant_d    = win;
                    pref_d     = ~win;
                    cnt_d      = '0;
                end
            end
            S_STROBE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ready takes priority over a timeout landing in the same cycle.
                if (i_bus_data_ready) begin
                    bus_clk_d = 1'b0;
                    done      = 1'b1;
                    done_data = i_bus_data;
                end else if (timed_out) begin
                    bus_clk_d = 1'b0;
                    done      = 1'b1;
                    done_err  = 1'b1;
                    done_data = '1;
                end
            end
            default: ;
        endcase
        if (done) begin
            if (grant_q) begin
                m1_ack_d   = 1'b1;
                m1_err_d   = done_err;
                m1_rdata_d = done_data;
            end else begin
                m0_ack_d   = 1'b1;
                m0_err_d   = done_err;
                m0_rdata_d = done_data;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q      <= '0;
            pref_q     <= 1'b0;
            grant_q    <= 1'b0;
            busy_q     <= 1'b0;
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pref_q     <= pref_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            bus_clk_q  <= bus_clk_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            m0_ack_q   <= m0_ack_d;
            m0_err_q   <= m0_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_ack_q   <= m1_ack_d;
            m1_err_q   <= m1_err_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign o_m0_ack   = m0_ack_q;
    assign o_m0_err   = m0_err_q;
    assign o_m0_rdata = m0_rdata_q;
    assign o_m1_ack   = m1_ack_q;
    assign o_m1_err   = m1_err_q;
    assign o_m1_rdata = m1_rdata_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;
    assign o_grant    = grant_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter: reads, writes, contention, timeout, stuck ready, async reset.
module tb_ext_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_m0_req, i_m0_we, i_m1_req, i_m1_we;
    logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_bus_clk, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_data;
    logic [31:0] i_bus_data;
    logic        i_bus_data_ready;
    logic        o_grant, o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int hi_cnt;
    logic [31:0] exp_m;

    ext_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(64), .CNT_W(7)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
        .o_bus_clk(o_bus_clk), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_data(o_bus_data),
        .i_bus_data(i_bus_data), .i_bus_data_ready(i_bus_data_ready),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_m0_req = 0; i_m0_we = 0; i_m0_addr = 0; i_m0_wdata = 0;
        i_m1_req = 0; i_m1_we = 0; i_m1_addr = 0; i_m1_wdata = 0;
        i_bus_data = 0; i_bus_data_ready = 0;
        tick(2);
        check("rst_bus_clk", {31'd0, o_bus_clk}, 0);
        check("rst_busy", {31'd0, o_busy}, 0);
        check("rst_grant", {31'd0, o_grant}, 0);
        check("rst_m0_rdata", o_m0_rdata, 0);
        i_rst = 1'b0;
        tick(1);

        // Single uncontested read by m0
        i_m0_req = 1; i_m0_we = 0; i_m0_addr = 32'h0000_1234;
        tick(1);
        check("rd_bus_clk", {31'd0, o_bus_clk}, 1);
        check("rd_bus_we", {31'd0, o_bus_we}, 0);
        check("rd_bus_addr", o_bus_addr, 32'h0000_1234);
        check("rd_busy", {31'd0, o_busy}, 1);
        check("rd_grant", {31'd0, o_grant}, 0);
        tick(1);
        check("rd_no_early_ack", {31'd0, o_m0_ack}, 0);
        i_bus_data_ready = 1; i_bus_data = 32'h0000_00A5;
        tick(1);
        check("rd_ack", {31'd0, o_m0_ack}, 1);
        check("rd_err", {31'd0, o_m0_err}, 0);
        check("rd_rdata", o_m0_rdata, 32'h0000_00A5);
        check("rd_bus_clk_low", {31'd0, o_bus_clk}, 0);
        i_m0_req = 0; i_bus_data_ready = 0;
        tick(1);
        check("rd_ack_pulse", {31'd0, o_m0_ack}, 0);
        check("rd_rdata_hold", o_m0_rdata, 32'h0000_00A5);
        check("rd_idle", {31'd0, o_busy}, 0);

        // Write by m1; m0 outputs must stay put
        i_m1_req = 1; i_m1_we = 1; i_m1_addr = 32'h0000_9F00; i_m1_wdata = 32'h0000_0042;
        tick(1);
        check("wr_grant", {31'd0, o_grant}, 1);
        check("wr_we", {31'd0, o_bus_we}, 1);
        check("wr_addr", o_bus_addr, 32'h0000_9F00);
        check("wr_data", o_bus_data, 32'h0000_0042);
        i_m1_wdata = 32'h0000_DEAD;
        tick(1);
        check("wr_data_latched", o_bus_data, 32'h0000_0042);
        i_bus_data_ready = 1; i_bus_data = 32'h0000_0077;
        tick(1);
        check("wr_m1_ack", {31'd0, o_m1_ack}, 1);
        check("wr_m1_err", {31'd0, o_m1_err}, 0);
        check("wr_m0_ack_quiet", {31'd0, o_m0_ack}, 0);
        check("wr_m0_rdata_kept", o_m0_rdata, 32'h0000_00A5);
        i_m1_req = 0; i_m1_we = 0; i_bus_data_ready = 0;
        tick(1);

        // Contention: last grant was m1, so m0 goes first, then strict alternation
        i_m0_req = 1; i_m0_we = 0; i_m0_addr = 32'h0000_0100;
        i_m1_req = 1; i_m1_we = 0; i_m1_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("ct_grant%0d", i), {31'd0, o_grant}, i % 2);
            check($sformatf("ct_strobe%0d", i), {31'd0, o_bus_clk}, 1);
            exp_m = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            check($sformatf("ct_addr%0d", i), o_bus_addr, exp_m);
            i_bus_data_ready = 1; i_bus_data = 32'h100 + i;
            tick(1);
            if (i % 2 == 0) begin
                check($sformatf("ct_m0_ack%0d", i), {31'd0, o_m0_ack}, 1);
                check($sformatf("ct_m1_quiet%0d", i), {31'd0, o_m1_ack}, 0);
                check($sformatf("ct_m0_rdata%0d", i), o_m0_rdata, 32'h100 + i);
            end else begin
                check($sformatf("ct_m1_ack%0d", i), {31'd0, o_m1_ack}, 1);
                check($sformatf("ct_m0_quiet%0d", i), {31'd0, o_m0_ack}, 0);
                check($sformatf("ct_m1_rdata%0d", i), o_m1_rdata, 32'h100 + i);
            end
            i_bus_data_ready = 0;
            tick(1);
        end
        i_m0_req = 0; i_m1_req = 0;
        tick(1);

        // Timeout: slave never readies, strobe must last exactly TIMEOUT cycles
        i_m0_req = 1; i_m0_addr = 32'h0000_4000;
        tick(1);
        hi_cnt = 0;
        while (o_bus_clk && hi_cnt < 200) begin
            hi_cnt++;
            tick(1);
        end
        check("to_strobe_len", hi_cnt, 64);
        check("to_ack", {31'd0, o_m0_ack}, 1);
        check("to_err", {31'd0, o_m0_err}, 1);
        check("to_rdata", o_m0_rdata, 32'hFFFF_FFFF);
        i_m0_req = 0;
        tick(1);
        check("to_err_pulse", {31'd0, o_m0_err}, 0);
        i_m0_req = 1; i_m0_addr = 32'h0000_0010;
        tick(1);
        check("to_next_strobe", {31'd0, o_bus_clk}, 1);
        i_bus_data_ready = 1; i_bus_data = 32'h0000_0055;
        tick(1);
        check("to_next_ack", {31'd0, o_m0_ack}, 1);
        check("to_next_err", {31'd0, o_m0_err}, 0);
        check("to_next_rdata", o_m0_rdata, 32'h0000_0055);
        i_m0_req = 0; i_bus_data_ready = 0;
        tick(1);

        // Ready stuck high after completion must not finish m1's pending request
        i_m0_req = 1; i_m0_addr = 32'h0000_0020;
        tick(1);
        i_bus_data_ready = 1; i_bus_data = 32'h0000_0066;
        i_m1_req = 1; i_m1_addr = 32'h0000_0030;
        tick(1);
        check("st_m0_ack", {31'd0, o_m0_ack}, 1);
        i_m0_req = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("st_no_ack%0d", i), {31'd0, o_m1_ack | o_m0_ack}, 0);
            check($sformatf("st_no_strobe%0d", i), {31'd0, o_bus_clk}, 0);
        end
        check("st_busy", {31'd0, o_busy}, 1);
        i_bus_data_ready = 0;
        tick(1);
        check("st_idle", {31'd0, o_busy}, 0);
        tick(1);
        check("st_m1_strobe", {31'd0, o_bus_clk}, 1);
        check("st_m1_grant", {31'd0, o_grant}, 1);
        check("st_m1_addr", o_bus_addr, 32'h0000_0030);
        tick(1);

        // Async reset in the middle of a strobe
        #3;
        i_rst = 1'b1;
        #1;
        check("ar_bus_clk", {31'd0, o_bus_clk}, 0);
        check("ar_busy", {31'd0, o_busy}, 0);
        check("ar_grant", {31'd0, o_grant}, 0);
        check("ar_m1_ack", {31'd0, o_m1_ack}, 0);
        check("ar_m0_rdata", o_m0_rdata, 0);
        tick(1);
        i_rst = 1'b0;
        i_m0_req = 1; i_m0_addr = 32'h0000_0040;
        i_m1_req = 1;
        tick(1);
        check("ar_grant_m0", {31'd0, o_grant}, 0);
        check("ar_strobe", {31'd0, o_bus_clk}, 1);
        check("ar_no_m1_ack", {31'd0, o_m1_ack}, 0);
        i_m0_req = 0; i_m1_req = 0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ext_bus_arbiter.md
Name: ext_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the CPU external memory bus (o_bus_clk / o_bus_we / o_bus_addr / o_bus_data / i_bus_data / i_bus_data_ready).
- Master 0 is the CPU load/store path; master 1 is the DMA/loader engine.
- Grants one transfer at a time with round-robin fairness and drives the strobe/ready handshake.
- Returns read data with a one-cycle ack pulse, or an error on timeout.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- TIMEOUT, 64, maximum strobe-high cycles before abort; must be at least 2.
- CNT_W, 7, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_m0_req  in  1  master 0 transfer request.
- i_m0_we  in  1  master 0 write enable (1 = write).
- i_m0_addr  in  ADDR_W  master 0 address.
- i_m0_wdata  in  DATA_W  master 0 write data.
- o_m0_ack  out  1  master 0 completion pulse.
- o_m0_err  out  1  master 0 timeout flag, valid with ack.
- o_m0_rdata  out  DATA_W  master 0 read data, valid with ack.
- i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, o_m1_ack, o_m1_err, o_m1_rdata  same as master 0, for master 1.
- o_bus_clk  out  1  bus strobe.
- o_bus_we  out  1  bus write enable.
- o_bus_addr  out  ADDR_W  bus address.
- o_bus_data  out  DATA_W  bus write data.
- i_bus_data  in  DATA_W  bus read data.
- i_bus_data_ready  in  1  slave completion.
- o_grant  out  1  index of the current or last granted master.
- o_busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async):
  - All outputs go to 0 immediately, including o_bus_clk, acks, errs, rdata, o_grant and o_busy.
  - State goes to IDLE, the timeout counter to 0, and the round-robin pointer to "master 0 preferred".
  - A reset mid-transfer drops the transfer with no ack.
- States: IDLE, STROBE, RELEASE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If only one master requests, it wins.
  - If both request, the preferred master wins; the preferred master is the one NOT granted last.
  - On a grant: latch the winner's we/addr/wdata into o_bus_we/o_bus_addr/o_bus_data, set o_bus_clk=1, set o_grant, clear the counter, go to STROBE. All of this is visible the cycle after the sampling edge.
  - With no request: stay in IDLE. o_bus_addr, o_bus_data and o_bus_we hold their last values.
- STROBE:
  - The counter increments each cycle.
  - If i_bus_data_ready=1: o_bus_clk<=0; grantee rdata<=i_bus_data (reads; writes also capture, value unspecified); grantee ack=1 for exactly one cycle with err=0; go to RELEASE.
  - Else if counter==TIMEOUT-1: o_bus_clk<=0; grantee ack=1 with err=1 and rdata=all ones; go to RELEASE.
  - Ready has priority over timeout in the same cycle.
- RELEASE:
  - Wait until i_bus_data_ready==0, then go to IDLE. This prevents one ready pulse from completing two transfers.
  - If ready is already low on entry, the block spends 1 cycle here.
- Round-robin pointer: updated at grant time so the other master is preferred next.
- Ack/err/rdata:
  - ack and err are registered, high for one cycle, then return to 0.
  - rdata holds until the next ack to the same master.
  - The other master's outputs are untouched.
- Requester rules:
  - Hold req and its fields stable until ack.
  - A req still high in the cycle after ack is a new request.
  - The arbiter latches fields at grant, so changes after grant are ignored.
- Latency, uncontested read:
  - req high at edge 0 → o_bus_clk high after edge 0.
  - Ready seen at edge k → ack and o_bus_clk low after edge k.
  - Minimum back-to-back period is 3 cycles.
- Outputs never glitch: every output is registered.

Test Plan:
- Single read, m0: addr=0x0000_1234; slave asserts ready with data 0xA5 two cycles after the strobe → o_bus_we=0, o_bus_addr=0x1234; o_m0_ack for 1 cycle with rdata=0x0000_00A5, err=0; o_bus_clk low the same cycle.
- Contention: m0 and m1 request every cycle (re-request after ack), slave ready 1 cycle after strobe → grants alternate m0, m1, m0, m1; o_grant follows 0, 1, 0, 1; each master gets 1 ack per 2 transfers.
- Write, m1: we=1, addr=0x0000_9F00, wdata=0x0000_0042 → bus shows we=1, addr=0x9F00, data=0x42 throughout the strobe; o_m1_ack pulses; m0 outputs unchanged.
- Timeout, TIMEOUT=64: slave never readies → o_bus_clk high exactly 64 cycles; o_m0_ack with err=1, rdata=0xFFFF_FFFF; next request is accepted normally.
- Ready stuck high after completion: ready held high 5 extra cycles with m1 requesting → arbiter stays in RELEASE, no second ack; m1 is granted 1 cycle after ready falls.
- Async reset mid-STROBE: assert i_rst between edges → o_bus_clk, o_busy and all acks drop immediately with no ack; after release, simultaneous requests grant m0 first.
